// File: rtl/kv_srl_fifo_p.sv
// kv_srl_fifo_p: parametrised common-clock FIFO built on an inferred
// addressable shift register. It supports standard or first-word-fall-through
// read, an occupancy count, almost flags and sticky error flags.
module kv_srl_fifo_p #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = 28,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             err_ovr,
  output logic             err_und
);

  // In FWFT mode the output register holds the head entry, so the chain needs one slot less.
  localparam int unsigned SD     = (FWFT != 0) ? DEPTH - 1 : DEPTH;
  localparam logic [CW-1:0] RD_OFS = (FWFT != 0) ? CW'(2) : CW'(1);

  logic [WIDTH-1:0] mem [SD];
  logic             wr_acc;
  logic             rd_acc;
  logic             shift_en;
  logic             load_d;
  logic             load_mem;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    rd_sel;
  logic [WIDTH-1:0] rd_data;

  // Request acceptance, next occupancy and output-stage steering.
  always_comb begin
    wr_acc     = wr_en & ~full;
    rd_acc     = rd_en & ~empty;
    count_next = count + CW'(wr_acc) - CW'(rd_acc);
    rd_sel     = count - RD_OFS;
    if (FWFT != 0) begin
      // The write bypasses the chain when the output stage is (or is becoming) free.
      load_d   = wr_acc & ((count == '0) | ((count == CW'(1)) & rd_acc));
      load_mem = rd_acc & (count >= CW'(2));
    end else begin
      load_d   = 1'b0;
      load_mem = rd_acc;
    end
    shift_en = wr_acc & ~load_d;
  end

  // Read-address mux; the oldest chain entry sits at the highest occupied index.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < SD; i++) begin
      if (rd_sel == CW'(i)) rd_data = mem[i];
    end
  end

  // Shift-register storage. It has no reset so it maps onto SRL cells; stale data is unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= d;
      for (int unsigned i = 1; i < SD; i++) mem[i] <= mem[i-1];
    end
  end

  // Occupancy, status flags, sticky errors and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      err_ovr      <= 1'b0;
      err_und      <= 1'b0;
      q            <= '0;
    end else begin
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CW'(DEPTH));
      almost_empty <= (count_next <= CW'(AE_THRESH));
      almost_full  <= (count_next >= CW'(AF_THRESH));
      err_ovr      <= (wr_en & full)  | (err_ovr & ~err_clr);
      err_und      <= (rd_en & empty) | (err_und & ~err_clr);
      if (load_d)        q <= d;
      else if (load_mem) q <= rd_data;
    end
  end

endmodule

// File: tb/tb_kv_srl_fifo_p.sv
// tb_kv_srl_fifo_p: directed checks on DEPTH=16 standard and FWFT instances,
// plus queue-model checking of six random-configuration instances every cycle.
module tb_kv_srl_fifo_p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  bit         chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Directed instances: standard and FWFT, DEPTH=16, AF=12, AE=2.
  logic [7:0] s_q, f_q;
  logic [4:0] s_cnt, f_cnt;
  logic s_em, s_fu, s_ae, s_af, s_ov, s_un;
  logic f_em, f_fu, f_ae, f_af, f_ov, f_un;

  kv_srl_fifo_p #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(12), .AE_THRESH(2)) u_std (
    .clk(clk), .rst(rst), .d(d), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .q(s_q), .empty(s_em), .full(s_fu), .almost_empty(s_ae), .almost_full(s_af),
    .count(s_cnt), .err_ovr(s_ov), .err_und(s_un));

  kv_srl_fifo_p #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(12), .AE_THRESH(2)) u_fwft (
    .clk(clk), .rst(rst), .d(d), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .q(f_q), .empty(f_em), .full(f_fu), .almost_empty(f_ae), .almost_full(f_af),
    .count(f_cnt), .err_ovr(f_ov), .err_und(f_un));

  // Random-configuration instances, each with its own queue reference model.
  localparam int unsigned NR = 6;
  localparam int unsigned RDEP [NR] = '{2, 17, 64, 2, 17, 64};
  localparam int unsigned RFW  [NR] = '{0, 0, 0, 1, 1, 1};

  for (genvar g = 0; g < NR; g++) begin : g_rand
    localparam int unsigned DP  = RDEP[g];
    localparam int unsigned FW  = RFW[g];
    localparam int unsigned AF  = DP - DP / 4;
    localparam int unsigned AE  = DP / 4;
    localparam int unsigned CWG = $clog2(DP + 1);

    logic [7:0]     rq;
    logic [CWG-1:0] rcnt;
    logic rem, rfu, rae, raf, rov, run;

    kv_srl_fifo_p #(.WIDTH(8), .DEPTH(DP), .FWFT(FW), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut (
      .clk(clk), .rst(rst), .d(d), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
      .q(rq), .empty(rem), .full(rfu), .almost_empty(rae), .almost_full(raf),
      .count(rcnt), .err_ovr(rov), .err_und(run));

    byte unsigned mq[$];
    bit           m_ovr, m_und;
    byte unsigned m_q;

    // Reference model: a queue with acceptance decided from the pre-edge occupancy.
    always @(posedge clk) begin
      int unsigned n;
      bit wa, ra;
      byte unsigned popped;
      n = mq.size();
      if (rst) begin
        mq.delete();
        m_ovr = 1'b0;
        m_und = 1'b0;
        m_q   = 8'h00;
      end else begin
        wa = wr_en && (n != DP);
        ra = rd_en && (n != 0);
        m_ovr = (wr_en && n == DP) || (m_ovr && !err_clr);
        m_und = (rd_en && n == 0)  || (m_und && !err_clr);
        if (ra) begin
          popped = mq.pop_front();
          if (FW == 0) m_q = popped;
        end
        if (wa) mq.push_back(d);
        if (FW != 0 && mq.size() != 0) m_q = mq[0];
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("r%0d.count", g), 32'(rcnt), 32'(mq.size()));
        check($sformatf("r%0d.empty", g), 32'(rem), 32'(mq.size() == 0));
        check($sformatf("r%0d.full", g),  32'(rfu), 32'(mq.size() == DP));
        check($sformatf("r%0d.ae", g),    32'(rae), 32'(mq.size() <= AE));
        check($sformatf("r%0d.af", g),    32'(raf), 32'(mq.size() >= AF));
        check($sformatf("r%0d.ovr", g),   32'(rov), 32'(m_ovr));
        check($sformatf("r%0d.und", g),   32'(run), 32'(m_und));
        if (FW == 0 || mq.size() != 0)
          check($sformatf("r%0d.q", g),   32'(rq),  32'(m_q));
      end
    end
  end

  task automatic drive(input bit w, input bit r, input logic [7:0] dv);
    wr_en = w;
    rd_en = r;
    d     = dv;
    @(negedge clk);
  endtask

  initial begin
    byte unsigned eq[$];
    byte unsigned ev;
    int wp, rp;

    // Reset and reset-state checks.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst.count", 32'(s_cnt), 0);
    check("rst.empty", 32'(s_em), 1);
    check("rst.full",  32'(s_fu), 0);
    check("rst.ae",    32'(s_ae), 1);
    check("rst.af",    32'(s_af), 0);
    check("rst.ovr",   32'(s_ov), 0);
    check("rst.und",   32'(s_un), 0);
    check("rst.q",     32'(s_q),  0);

    // Fill and drain, standard mode.
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 8'(i));
      check("fill.count", 32'(s_cnt), 32'(i));
      check("fill.af",    32'(s_af),  32'(i >= 12));
      check("fill.ae",    32'(s_ae),  32'(i <= 2));
      check("fill.full",  32'(s_fu),  32'(i == 16));
    end
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 8'h00);
      check("drain.q",     32'(s_q),  32'(i));
      check("drain.empty", 32'(s_em), 32'(i == 16));
    end

    // Overflow, underflow and error clearing.
    for (int i = 0; i < 16; i++) drive(1, 0, 8'(8'h20 + i));
    drive(1, 0, 8'hAA);
    check("ovr.flag",  32'(s_ov),  1);
    check("ovr.count", 32'(s_cnt), 16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'h00);
      check("ovr.drain", 32'(s_q), 32'(8'h20 + i));
    end
    check("ovr.hold", 32'(s_ov), 1);
    drive(0, 1, 8'h00);
    check("und.flag", 32'(s_un), 1);
    check("und.q",    32'(s_q),  32'h2F);
    err_clr = 1'b1;
    drive(0, 0, 8'h00);
    check("clr.ovr", 32'(s_ov), 0);
    check("clr.und", 32'(s_un), 0);
    drive(0, 1, 8'h00);
    err_clr = 1'b0;
    check("clr.setwins", 32'(s_un), 1);
    err_clr = 1'b1;
    drive(0, 0, 8'h00);
    err_clr = 1'b0;

    // Simultaneous read/write at count=5, then at full and at empty.
    for (int i = 0; i < 5; i++) begin
      eq.push_back(8'(8'h30 + i));
      drive(1, 0, 8'(8'h30 + i));
    end
    for (int i = 0; i < 20; i++) begin
      eq.push_back(8'(8'h40 + i));
      ev = eq.pop_front();
      drive(1, 1, 8'(8'h40 + i));
      check("sim.count", 32'(s_cnt), 5);
      check("sim.q",     32'(s_q),   32'(ev));
    end
    for (int i = 0; i < 11; i++) begin
      eq.push_back(8'(8'h60 + i));
      drive(1, 0, 8'(8'h60 + i));
    end
    check("simf.full", 32'(s_fu), 1);
    ev = eq.pop_front();
    drive(1, 1, 8'hEE);
    check("simf.count", 32'(s_cnt), 15);
    check("simf.ovr",   32'(s_ov),  1);
    check("simf.q",     32'(s_q),   32'(ev));
    for (int i = 0; i < 15; i++) begin
      ev = eq.pop_front();
      drive(0, 1, 8'h00);
      check("simf.drain", 32'(s_q), 32'(ev));
    end
    err_clr = 1'b1;
    drive(0, 0, 8'h00);
    err_clr = 1'b0;
    drive(1, 1, 8'h77);
    check("sime.count", 32'(s_cnt), 1);
    check("sime.und",   32'(s_un),  1);
    drive(0, 1, 8'h00);
    check("sime.q", 32'(s_q), 32'h77);

    // Reset mid-operation.
    for (int i = 0; i < 9; i++) drive(1, 0, 8'(8'h90 + i));
    check("mid.count9", 32'(s_cnt), 9);
    rst = 1'b1;
    drive(1, 0, 8'h12);
    rst = 1'b0;
    check("mid.count", 32'(s_cnt), 0);
    check("mid.empty", 32'(s_em),  1);
    check("mid.q",     32'(s_q),   0);
    check("mid.ovr",   32'(s_ov),  0);
    check("mid.und",   32'(s_un),  0);
    drive(1, 0, 8'h55);
    drive(0, 1, 8'h00);
    check("mid.q55", 32'(s_q), 32'h55);

    // FWFT mode.
    rst = 1'b1;
    drive(0, 0, 8'h00);
    rst = 1'b0;
    drive(1, 0, 8'h3C);
    check("fw.q3c",   32'(f_q),  32'h3C);
    check("fw.empty", 32'(f_em), 0);
    drive(1, 1, 8'h3D);
    check("fw.q3d",   32'(f_q),   32'h3D);
    check("fw.nempty", 32'(f_em), 0);
    check("fw.count1", 32'(f_cnt), 1);
    drive(0, 1, 8'h00);
    check("fw.empty1", 32'(f_em),  1);
    check("fw.count0", 32'(f_cnt), 0);
    for (int i = 0; i < 16; i++) drive(1, 0, 8'(8'h80 + i));
    check("fw.full",  32'(f_fu),  1);
    check("fw.count", 32'(f_cnt), 16);
    for (int i = 0; i < 16; i++) begin
      check("fw.head", 32'(f_q), 32'(8'h80 + i));
      drive(0, 1, 8'h00);
    end
    check("fw.drained", 32'(f_em), 1);

    // Random traffic with phase-varying write/read pressure.
    wp = 50;
    rp = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 400 == 0) begin
        wp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      rst     = ($urandom_range(0, 999) == 0);
      err_clr = ($urandom_range(0, 99) < 3);
      d       = 8'($urandom);
      wr_en   = ($urandom_range(0, 99) < wp);
      rd_en   = ($urandom_range(0, 99) < rp);
      @(negedge clk);
    end
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    @(posedge clk);
    chk_en = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
